ram_bist: RTL

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_bist.sv
// Write/read-compare BIST for a 128x8 synchronous RAM; optional inverted second pass
// is enabled by defining RAM_BIST_INVERT_PASS_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WRITE   | writing exp(a) to addresses 0..127
// READ    | issuing reads 0..127, comparing the previous read each cycle
// CHECK   | compare of the final read, then next pass or DONE
// DONE    | result held until the next accepted start
module ram_bist #(
    parameter logic [7:0] PAT = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_addr,
    output logic [7:0] fail_data,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] fail_addr_q, fail_addr_d;
    logic [7:0] fail_data_q, fail_data_d;
    logic       we_q, we_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       cmp_vld_q, cmp_vld_d;
    logic [6:0] cmp_addr_q, cmp_addr_d;
    logic [7:0] pass_mask;
    logic       mismatch;

`ifdef RAM_BIST_INVERT_PASS_EN
    logic       inv_q, inv_d;
    assign pass_mask = {8{inv_q}};
`else
    assign pass_mask = 8'h00;
`endif

    function automatic logic [7:0] exp_fn(input logic [6:0] a, input logic [7:0] mask);
        exp_fn = PAT ^ {1'b0, a} ^ mask;
    endfunction

    // cmp_vld_q marks that mem_rdata this cycle belongs to the read issued last cycle
    assign mismatch = cmp_vld_q && (mem_rdata != exp_fn(cmp_addr_q, pass_mask));

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr_q;
`ifdef RAM_BIST_INVERT_PASS_EN
        inv_d       = inv_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = 7'd0;
                    fail_data_d = 8'd0;
                    we_d        = 1'b1;
                    addr_d      = 7'd0;
                    wdata_d     = exp_fn(7'd0, 8'h00);
`ifdef RAM_BIST_INVERT_PASS_EN
                    inv_d       = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                if (addr_q == 7'd127) begin
                    state_d = S_READ;
                    we_d    = 1'b0;
                    addr_d  = 7'd0;
                    wdata_d = 8'd0;
                end else begin
                    addr_d  = addr_q + 7'd1;
                    wdata_d = exp_fn(addr_q + 7'd1, pass_mask);
                end
            end
            S_READ, S_CHECK: begin
                if (mismatch) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = cmp_addr_q;
                    fail_data_d = mem_rdata;
                end else if (state_q == S_READ) begin
                    cmp_vld_d  = 1'b1;
                    cmp_addr_d = addr_q;
                    if (addr_q == 7'd127) state_d = S_CHECK;
                    else addr_d = addr_q + 7'd1;
                end else begin
`ifdef RAM_BIST_INVERT_PASS_EN
                    if (!inv_q) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = 7'd0;
                        wdata_d = exp_fn(7'd0, 8'hFF);
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= 7'd0;
            fail_data_q <= 8'd0;
            we_q        <= 1'b0;
            addr_q      <= 7'd0;
            wdata_q     <= 8'd0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= 7'd0;
`ifdef RAM_BIST_INVERT_PASS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
`ifdef RAM_BIST_INVERT_PASS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
